// File: rtl/wb_regfile.sv
// Write-back stage: WB pipeline latch feeding an 8x16 architectural register file.
// Optional read forwarding of the pending write is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              stall,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic              wr_pending,
  output logic [15:0]       commit_cnt
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              lat_v;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              capture;

  assign capture = wb_valid & wb_regwrite & ~stall;

  // Commit drains the latch regardless of stall; stall only starves the latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_v      <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      commit_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      lat_v <= capture;
      if (capture) begin
        lat_addr <= wb_waddr;
        lat_data <= wb_wdata;
      end
      if (lat_v) begin
        mem[lat_addr] <= lat_data;
        if (commit_cnt != 16'hFFFF) begin
          commit_cnt <= commit_cnt + 16'd1;
        end
      end
    end
  end

  assign wr_pending = lat_v;

  always_comb begin
    rd1_data = mem[rd1_addr];
    rd2_data = mem[rd2_addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (lat_v && (rd1_addr == lat_addr)) rd1_data = lat_data;
    if (lat_v && (rd2_addr == lat_addr)) rd2_data = lat_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus random traffic
// against a write-queue reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_regwrite, stall;
  logic [2:0]  wb_waddr, rd1_addr, rd2_addr;
  logic [15:0] wb_wdata, rd1_data, rd2_data, commit_cnt;
  logic        wr_pending;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural registers, at most one write awaiting commit,
  // and the number of writes committed so far (clipped when reported).
  int unsigned ref_mem [8];
  logic        pend_v;
  int unsigned pend_a, pend_d;
  longint      ref_commits;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .stall(stall),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .wr_pending(wr_pending), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input int unsigned a);
`ifdef WB_REGFILE_BYPASS_EN
    if (pend_v && a == pend_a) return pend_d[15:0];
`endif
    return ref_mem[a][15:0];
  endfunction

  function automatic logic [15:0] exp_cnt();
    return (ref_commits > 65535) ? 16'hFFFF : ref_commits[15:0];
  endfunction

  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = 0;
    pend_v = 1'b0; pend_a = 0; pend_d = 0;
    ref_commits = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pending"}, {31'd0, wr_pending}, {31'd0, pend_v});
    chk({tag, ".cnt"}, {16'd0, commit_cnt}, {16'd0, exp_cnt()});
    chk({tag, ".rd1"}, {16'd0, rd1_data}, {16'd0, exp_rd(rd1_addr)});
    chk({tag, ".rd2"}, {16'd0, rd2_data}, {16'd0, exp_rd(rd2_addr)});
  endtask

  // One clock: drive at negedge, update model at posedge, check 1ns later.
  task automatic cycle(input logic v, input logic rw, input logic [2:0] a,
                       input logic [15:0] d, input logic st,
                       input logic [2:0] r1, input logic [2:0] r2,
                       input bit do_chk, input string tag);
    @(negedge clk);
    wb_valid = v; wb_regwrite = rw; wb_waddr = a; wb_wdata = d; stall = st;
    rd1_addr = r1; rd2_addr = r2;
    @(posedge clk);
    if (pend_v) begin
      ref_mem[pend_a] = pend_d;
      ref_commits++;
    end
    pend_v = (v === 1'b1) && (rw === 1'b1) && (st === 1'b0);
    if (pend_v) begin
      pend_a = a; pend_d = d;
    end
    #1;
    if (do_chk) check_outputs(tag);
  endtask

  task automatic idle(input logic [2:0] r1, input logic [2:0] r2, input string tag);
    cycle(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, r1, r2, 1'b1, tag);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    wb_valid = 0; wb_regwrite = 0; wb_waddr = 0; wb_wdata = 0; stall = 0;
    rd1_addr = 0; rd2_addr = 7;
    #12;
    check_outputs("reset_init");
    @(negedge clk); rst = 1'b1;

    // Basic write of R3 with forwarding/no-forwarding visibility between edges.
    cycle(1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd3, 3'd3, 1'b1, "basic_capture");
`ifdef WB_REGFILE_BYPASS_EN
    chk("bypass_r3", {16'd0, rd1_data}, 32'h0000BEEF);
`else
    chk("nobypass_r3", {16'd0, rd1_data}, 32'h00000000);
`endif
    idle(3'd3, 3'd0, "basic_commit");
    chk("basic_r3", {16'd0, rd1_data}, 32'h0000BEEF);
    chk("basic_cnt", {16'd0, commit_cnt}, 32'd1);

    // regwrite=0 and stall gating; X on address/data while nothing is captured.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 3'($urandom), 16'($urandom), 1'b0, 3'd3, 3'($urandom), 1'b1, "norw");
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 3'($urandom), 16'($urandom), 1'b1, 3'd3, 3'($urandom), 1'b1, "stall");
    cycle(1'b0, 1'bx, 3'bxxx, 16'hxxxx, 1'b0, 3'd3, 3'd0, 1'b1, "x_idle");
    cycle(1'b1, 1'b1, 3'bxxx, 16'hxxxx, 1'b1, 3'd3, 3'd0, 1'b1, "x_stall");
    chk("gate_cnt", {16'd0, commit_cnt}, 32'd1);
    chk("gate_r3", {16'd0, rd1_data}, 32'h0000BEEF);

    // Stream R5 = 1,2,3 back to back, then a stalled write behind it.
    for (int i = 1; i <= 3; i++)
      cycle(1'b1, 1'b1, 3'd5, 16'(i), 1'b0, 3'd5, 3'd5, 1'b1, "stream");
    cycle(1'b1, 1'b1, 3'd5, 16'h00AA, 1'b1, 3'd5, 3'd5, 1'b1, "stream_stall");
    idle(3'd5, 3'd5, "stream_end");
    chk("stream_r5", {16'd0, rd1_data}, 32'd3);
    chk("stream_agree", {16'd0, rd1_data}, {16'd0, rd2_data});
    chk("stream_cnt", {16'd0, commit_cnt}, 32'd4);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom), 1'b1, "rand");

    // Asynchronous reset mid-cycle while a write is pending.
    cycle(1'b1, 1'b1, 3'd6, 16'h1234, 1'b0, 3'd6, 3'd6, 1'b1, "pre_reset");
    chk("pre_reset_pend", {31'd0, wr_pending}, 32'd1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_pending", {31'd0, wr_pending}, 32'd0);
    chk("rst_cnt", {16'd0, commit_cnt}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      rd1_addr = 3'(r); rd2_addr = 3'(7 - r);
      #1;
      chk("rst_rd1", {16'd0, rd1_data}, 32'd0);
      chk("rst_rd2", {16'd0, rd2_data}, 32'd0);
    end
    @(negedge clk);
    wb_valid = 0; wb_regwrite = 0; stall = 0;
    rst = 1'b1;
    idle(3'd6, 3'd6, "post_reset");
    idle(3'd6, 3'd0, "post_reset2");
    chk("discarded_r6", {16'd0, rd1_data}, 32'd0);
    chk("discarded_cnt", {16'd0, commit_cnt}, 32'd0);

    // Saturation: 65534 commits lands on FFFE, three more must hold at FFFF.
    for (int i = 0; i < 65534; i++)
      cycle(1'b1, 1'b1, 3'd7, 16'(i), 1'b0, 3'd7, 3'd0, 1'b0, "sat");
    idle(3'd7, 3'd0, "sat_fffe");
    chk("sat_fffe", {16'd0, commit_cnt}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 3'd7, 16'hC000 + 16'(i), 1'b0, 3'd7, 3'd0, 1'b1, "sat_edge");
    idle(3'd7, 3'd0, "sat_hold");
    chk("sat_ffff", {16'd0, commit_cnt}, 32'h0000FFFF);
    chk("sat_r7", {16'd0, rd1_data}, 32'h0000C002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
